// File: rtl/adder_share_arb.sv
// adder_share_arb
//
// Round-robin arbiter and sequencer that shares one 8-bit ripple-carry adder
// among four requesters. A request is accepted only in IDLE. Its operands are
// registered, added in ADD, and the registered result is held in HOLD until
// the consumer takes it.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   req_valid  [3:0]  per-requester valid
//   req_a      [31:0] operand A, requester i in bits [8i+7:8i]
//   req_b      [31:0] operand B, same packing
//   req_ready  [3:0]  one-hot combinational grant, only in IDLE
//   res_valid         result valid (HOLD)
//   res_ready         consumer accepts result
//   res_sum    [7:0]  (A + B) mod 256
//   res_carry         carry-out of bit 7
//   res_id     [1:0]  requester that owns the result
//   busy              high in ADD or HOLD

module adder_share_arb #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WIDTH-1:0]       res_sum,
   output logic                   res_carry,
   output logic [1:0]             res_id,
   output logic                   busy
);

   typedef enum logic [1:0] {StIdle, StAdd, StHold} state_e;

   state_e           state_q, state_d;
   logic [1:0]       ptr_q;
   logic [1:0]       id_q;
   logic [WIDTH-1:0] op_a_q, op_b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic [1:0]       res_id_q;

   logic             gnt_found;
   logic [1:0]       gnt_idx;
   logic             accept;
   logic [WIDTH-1:0] add_sum;
   logic             add_carry;

   // First valid requester searching upward from ptr, wrapping 3 -> 0.
   always_comb begin
      logic [1:0] idx;
      gnt_found = 1'b0;
      gnt_idx   = ptr_q;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

   // Shared ripple-carry adder, carry-in tied low.
   always_comb begin
      logic c;
      c       = 1'b0;
      add_sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         add_sum[i] = op_a_q[i] ^ op_b_q[i] ^ c;
         c          = (op_a_q[i] & op_b_q[i]) | (c & (op_a_q[i] ^ op_b_q[i]));
      end
      add_carry = c;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      case (state_q)
         StIdle: begin
            if (gnt_found) begin
               req_ready[gnt_idx] = 1'b1;
               accept             = 1'b1;
               state_d            = StAdd;
            end
         end
         StAdd: state_d = StHold;
         StHold: begin
            if (res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // A grant in a reset cycle would be discarded, so do not advertise it.
      if (rst) req_ready = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= '0;
         id_q     <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         res_id_q <= '0;
      end else begin
         if (accept) begin
            op_a_q <= req_a[WIDTH*32'(gnt_idx) +: WIDTH];
            op_b_q <= req_b[WIDTH*32'(gnt_idx) +: WIDTH];
            id_q   <= gnt_idx;
            ptr_q  <= gnt_idx + 2'd1;
         end
         if (state_q == StAdd) begin
            sum_q    <= add_sum;
            carry_q  <= add_carry;
            res_id_q <= id_q;
         end
      end
   end

   assign res_valid = (state_q == StHold) && !rst;
   assign res_sum   = sum_q;
   assign res_carry = carry_q;
   assign res_id    = res_id_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_sum;
   logic        res_carry;
   logic [1:0]  res_id;
   logic        busy;

   adder_share_arb dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_carry (res_carry),
      .res_id    (res_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: expected result = {id, 9-bit unsigned a+b}.
   logic [10:0] q[$];
   bit          outstanding = 0;
   int          acc_cyc     = 0;
   int          last        = 3;   // previous grant; ptr=0 means search starts at 0
   bit          rst_seen    = 0;

   function automatic logic [3:0] exp_grant(input logic [3:0] v, input int lst);
      for (int k = 1; k <= 4; k++) begin
         int idx = (lst + k) % 4;
         if (v[idx]) return 4'(1 << idx);
      end
      return 4'b0000;
   endfunction

   always @(negedge clk) begin
      logic [3:0] eg;
      logic       ev;
      int         gi;
      if (rst) begin
         chk("ready_in_reset", {28'd0, req_ready}, 0);
         chk("valid_in_reset", {31'd0, res_valid}, 0);
         outstanding = 0;
         q.delete();
         last     = 3;
         rst_seen = 1;
      end else begin
         if (rst_seen) begin
            chk("reset_sum",   {24'd0, res_sum}, 0);
            chk("reset_carry", {31'd0, res_carry}, 0);
            chk("reset_id",    {30'd0, res_id}, 0);
            rst_seen = 0;
         end
         eg = outstanding ? 4'b0000 : exp_grant(req_valid, last);
         chk("grant", {28'd0, req_ready}, {28'd0, eg});
         ev = outstanding && (cyc - acc_cyc >= 2);
         chk("res_valid", {31'd0, res_valid}, {31'd0, ev});
         chk("busy", {31'd0, busy}, {31'd0, outstanding});
         if (res_valid && q.size() > 0) begin
            chk("res_sum",   {24'd0, res_sum},   {24'd0, q[0][7:0]});
            chk("res_carry", {31'd0, res_carry}, {31'd0, q[0][8]});
            chk("res_id",    {30'd0, res_id},    {30'd0, q[0][10:9]});
         end
         if (ev && res_ready) begin
            void'(q.pop_front());
            outstanding = 0;
         end
         if (eg != 0) begin
            gi = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) gi = i;
            q.push_back({2'(gi), 9'(int'(req_a[8*gi +: 8]) + int'(req_b[8*gi +: 8]))});
            outstanding = 1;
            acc_cyc     = cyc;
            last        = gi;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[8*i +: 8] = a;
      req_b[8*i +: 8] = b;
   endtask

   task automatic wait_res_valid();
      int i;
      for (i = 0; i < 10 && !res_valid; i++) step(1);
      if (!res_valid) chk("wait_res_valid", 0, 1);
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
      step(3);
      rst = 1'b0;

      // Single request: 200 + 100 = 44 carry 1.
      set_ops(0, 8'd200, 8'd100);
      req_valid = 4'b0001;
      step(1);
      req_valid = '0;
      step(4);

      // Round-robin from a freshly reset pointer.
      rst = 1'b1; step(1); rst = 1'b0;
      set_ops(0, 8'd3, 8'd4);
      set_ops(1, 8'd10, 8'd20);
      set_ops(2, 8'd255, 8'd1);
      set_ops(3, 8'd128, 8'd128);
      req_valid = 4'b1111;
      step(15);
      req_valid = '0;
      step(4);

      // Backpressure with requester 1 waiting.
      set_ops(1, 8'd77, 8'd200);
      req_valid = 4'b0010;
      wait_res_valid();
      res_ready = 1'b0;
      step(5);
      res_ready = 1'b1;
      step(7);
      req_valid = '0;
      step(4);

      // Pointer wrap: grant 3, then 0 before 3.
      set_ops(3, 8'd9, 8'd250);
      set_ops(0, 8'd1, 8'd2);
      req_valid = 4'b1000;
      step(1);
      req_valid = 4'b1001;
      step(8);
      req_valid = '0;
      step(4);

      // Reset during ADD.
      req_valid = 4'b0001;
      step(1);
      req_valid = '0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      set_ops(2, 8'd40, 8'd2);
      req_valid = 4'b0100;
      step(1);
      req_valid = '0;
      step(4);

      // Requester 1 only valid during HOLD.
      req_valid = 4'b0001;
      step(1);
      req_valid = '0;
      step(1);
      res_ready = 1'b0;
      req_valid = 4'b0010;
      step(2);
      req_valid = '0;
      res_ready = 1'b1;
      step(5);

      // Random traffic.
      for (int n = 0; n < 2000; n++) begin
         req_valid = 4'($urandom);
         req_a     = $urandom;
         req_b     = $urandom;
         res_ready = ($urandom_range(9) < 7);
         rst       = ($urandom_range(99) == 0);
         step(1);
      end
      rst = 1'b0; req_valid = '0; res_ready = 1'b1;
      step(5);
      chk("drain_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
